// File: rtl/matrix_scanner_if.sv
// Grid inputs and LED matrix drive outputs of the bicolour matrix scanner.
// MATRIX_SCANNER_BRIGHTNESS_EN adds the 3-bit brightness input.
interface matrix_scanner_if;
    logic [7:0][7:0] green_grid;
    logic [7:0][7:0] blue_grid;
    logic [7:0]      row_anode;
    logic [7:0]      green_cathode;
    logic [7:0]      blue_cathode;
    logic            frame_start;
`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
    logic [2:0]      brightness;

    modport master (output green_grid, blue_grid, brightness,
                    input  row_anode, green_cathode, blue_cathode, frame_start);
    modport slave  (input  green_grid, blue_grid, brightness,
                    output row_anode, green_cathode, blue_cathode, frame_start);
`else
    modport master (output green_grid, blue_grid,
                    input  row_anode, green_cathode, blue_cathode, frame_start);
    modport slave  (input  green_grid, blue_grid,
                    output row_anode, green_cathode, blue_cathode, frame_start);
`endif
endinterface

// File: rtl/matrix_scanner.sv
// Row-multiplexed bicolour 8x8 LED matrix scanner with per-frame grid latch and inter-row blanking.
// Optional MATRIX_SCANNER_BRIGHTNESS_EN: per-frame brightness trims the lit part of each dwell.
module matrix_scanner #(
    parameter int DWELL_CYCLES = 12500,
    parameter int BLANK_CYCLES = 16
) (
    input logic             clock,
    input logic             rst,
    matrix_scanner_if.slave scan
);
    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      row, row_nxt;
    logic            latch;
    logic [7:0][7:0] green_sh, blue_sh;
    logic [7:0]      anode_nxt, green_nxt, blue_nxt;

`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
    logic [2:0] bright_q, bright_nxt;

    // Cathodes are lit only for the first max(1, (b+1)*DWELL/8) cycles of the dwell.
    function automatic logic lit_cycle(input logic [CW-1:0] k, input logic [2:0] b);
        int on;
        on = ((int'(b) + 1) * DWELL_CYCLES) / 8;
        if (on < 1) on = 1;
        return int'(k) < on;
    endfunction
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        row_nxt   = row;
        latch     = 1'b0;
        case (state)
            BLANK: if (cnt == BLANK_LAST) begin
                state_nxt = DRIVE;
                cnt_nxt   = '0;
                latch     = (row == 3'd0);
            end
            DRIVE: if (cnt == DWELL_LAST) begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                row_nxt   = row + 3'd1;
            end
            default: state_nxt = BLANK;
        endcase

`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
        bright_nxt = latch ? scan.brightness : bright_q;
`endif
        // Output values are computed for the next cycle so every output is a flop.
        anode_nxt = 8'h00;
        green_nxt = 8'hFF;
        blue_nxt  = 8'hFF;
        if (state_nxt == DRIVE) begin
            anode_nxt = 8'h01 << row_nxt;
            green_nxt = latch ? scan.green_grid[row_nxt] : green_sh[row_nxt];
            blue_nxt  = latch ? scan.blue_grid[row_nxt]  : blue_sh[row_nxt];
`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
            if (!lit_cycle(cnt_nxt, bright_nxt)) begin
                green_nxt = 8'hFF;
                blue_nxt  = 8'hFF;
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            row   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            row   <= row_nxt;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            green_sh <= '1;
            blue_sh  <= '1;
        end else if (latch) begin
            green_sh <= scan.green_grid;
            blue_sh  <= scan.blue_grid;
        end
    end

`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) bright_q <= 3'd7;
        else     bright_q <= bright_nxt;
    end
`endif

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            scan.row_anode     <= 8'h00;
            scan.green_cathode <= 8'hFF;
            scan.blue_cathode  <= 8'hFF;
            scan.frame_start   <= 1'b0;
        end else begin
            scan.row_anode     <= anode_nxt;
            scan.green_cathode <= green_nxt;
            scan.blue_cathode  <= blue_nxt;
            scan.frame_start   <= latch;
        end
    end
endmodule

// File: tb/tb_matrix_scanner.sv
// Scoreboard bench for matrix_scanner: a frame-position model pushes expected outputs each edge.
module tb_matrix_scanner;
    localparam int TB_DWELL = 8;
    localparam int TB_BLANK = 2;
    localparam int ROWP     = TB_DWELL + TB_BLANK;
    localparam int FRAME    = 8 * ROWP;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] gc;
        logic [7:0] bc;
        logic       fs;
    } exp_t;

    logic clock;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic [7:0][7:0] sh_g, sh_b;
    logic [2:0]      br_q;
    logic [2:0]      bright_in;
    logic            latch_now;
    exp_t            q[$];

    matrix_scanner_if ifc();

    matrix_scanner #(.DWELL_CYCLES(TB_DWELL), .BLANK_CYCLES(TB_BLANK)) dut (
        .clock (clock),
        .rst   (rst),
        .scan  (ifc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
    assign bright_in = ifc.brightness;
`else
    assign bright_in = 3'd7;
`endif
    assign latch_now = ((n + 1) % FRAME) == TB_BLANK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, want, $time);
        end
    endtask

    // Expected outputs after nn edges since reset release, from position within the frame.
    function automatic exp_t exp_fn(input int nn, input logic [7:0][7:0] g, input logic [7:0][7:0] b,
                                    input logic [2:0] br);
        exp_t e;
        int p, r, w, on;
        p = nn % FRAME;
        r = p / ROWP;
        w = p % ROWP;
        e.an = 8'h00;
        e.gc = 8'hFF;
        e.bc = 8'hFF;
        e.fs = 1'b0;
        if (w >= TB_BLANK) begin
            e.an = 8'(1 << r);
            e.fs = (p == TB_BLANK);
            on = ((int'(br) + 1) * TB_DWELL) / 8;
            if (on < 1) on = 1;
            if (w - TB_BLANK < on) begin
                e.gc = g[r];
                e.bc = b[r];
            end
        end
        return e;
    endfunction

    always @(posedge clock or posedge rst) begin
        if (rst) begin
            n    <= 0;
            sh_g <= '1;
            sh_b <= '1;
            br_q <= 3'd7;
            q.delete();
        end else begin
            q.push_back(exp_fn(n + 1,
                               latch_now ? ifc.green_grid : sh_g,
                               latch_now ? ifc.blue_grid  : sh_b,
                               latch_now ? bright_in      : br_q));
            n <= n + 1;
            if (latch_now) begin
                sh_g <= ifc.green_grid;
                sh_b <= ifc.blue_grid;
                br_q <= bright_in;
            end
        end
    end

    always @(negedge clock) begin
        if (rst) begin
            check("rst_anode", ifc.row_anode, 8'h00);
            check("rst_green", ifc.green_cathode, 8'hFF);
            check("rst_blue", ifc.blue_cathode, 8'hFF);
            check("rst_fs", {7'd0, ifc.frame_start}, 8'd0);
        end else if (q.size() == 0) begin
            check("sb_depth", 8'(q.size()), 8'd1);
        end else begin
            check("anode", ifc.row_anode, q[0].an);
            check("green", ifc.green_cathode, q[0].gc);
            check("blue", ifc.blue_cathode, q[0].bc);
            check("frame_start", {7'd0, ifc.frame_start}, {7'd0, q[0].fs});
            void'(q.pop_front());
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clock);
        #1;
    endtask

    task automatic wait_row(input logic [7:0] r);
        int i;
        i = 0;
        do begin
            @(negedge clock);
            i++;
        end while (ifc.row_anode != r && i < 400);
        if (ifc.row_anode != r) check("wait_row", ifc.row_anode, r);
    endtask

    initial begin
        rst = 1'b1;
        ifc.green_grid = '1;
        ifc.blue_grid  = '1;
`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
        ifc.brightness = 3'd7;
`endif
        run(3);
        rst = 1'b0;
        run(2 * FRAME + 5);

        // Single-row patterns on green row 3 and blue row 5.
        ifc.green_grid[3] = 8'hF7;
        ifc.blue_grid[5]  = 8'h7F;
        run(2 * FRAME);

        // Mid-frame change must wait for the next latch.
        wait_row(8'h04);
        #1;
        ifc.green_grid[6] = 8'h00;
        run(2 * FRAME);

        // Both dies lit at the same position.
        ifc.green_grid[2] = 8'hFB;
        ifc.blue_grid[2]  = 8'hFB;
        run(FRAME + 10);

        // Asynchronous reset during row 4 drive.
        wait_row(8'h10);
        #2;
        rst = 1'b1;
        #1;
        check("async_anode", ifc.row_anode, 8'h00);
        check("async_green", ifc.green_cathode, 8'hFF);
        check("async_blue", ifc.blue_cathode, 8'hFF);
        @(posedge clock);
        @(negedge clock);
        #1;
        rst = 1'b0;
        run(2 * FRAME);

`ifdef MATRIX_SCANNER_BRIGHTNESS_EN
        ifc.green_grid[0] = 8'h00;
        ifc.brightness = 3'd1;
        run(2 * FRAME);
        ifc.brightness = 3'd0;
        run(2 * FRAME);
        wait_row(8'h08);
        #1;
        ifc.brightness = 3'd5;
        run(2 * FRAME);
`endif

        for (int k = 0; k < 6; k++) begin
            run($urandom_range(5, 60));
            ifc.green_grid[$urandom_range(0, 7)] = 8'($urandom);
            ifc.blue_grid[$urandom_range(0, 7)]  = 8'($urandom);
        end
        run(2 * FRAME);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
